qsys_regfile_rw: RTL and testbench

- Parametrised Avalon-MM register file, the successor to the single 32-bit test register.
- Provides a read-only ID word, a committed-write counter, a lock control register and 2**ADDR_W-3 scratch registers.
- Scratch writes honour byteenable; reads return data one cycle later with readdatavalid.
- Sits on the Qsys fabric as a bring-up/bus-integrity target for MCU and host software.

---
 rtl/qsys_regfile_rw.sv | 97 +++++++++
 tb/tb_qsys_regfile_rw.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/qsys_regfile_rw.sv
// Avalon-MM bring-up register file: ID word, committed-write counter, lock
// control and byte-enabled scratch registers with fixed one-cycle read latency.
module qsys_regfile_rw #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ADDR_W    = 3,
  parameter logic [31:0] RESET_VAL = 32'h12345678,
  parameter logic [31:0] ID_VAL    = 32'h52475731
) (
  input  logic                csi_MCLK_clk,
  input  logic                rsi_MRST_reset_n,
  input  logic [ADDR_W-1:0]   avs_Reg_address,
  input  logic [DATA_W/8-1:0] avs_Reg_byteenable,
  input  logic                avs_Reg_read,
  output logic [DATA_W-1:0]   avs_Reg_readdata,
  output logic                avs_Reg_readdatavalid,
  input  logic                avs_Reg_write,
  input  logic [DATA_W-1:0]   avs_Reg_writedata,
  output logic                avs_Reg_waitrequest
);

  localparam int unsigned NUM_REGS = 2**ADDR_W;
  localparam int unsigned LANES    = DATA_W / 8;
  localparam logic [DATA_W-1:0] RESET_W = DATA_W'(RESET_VAL);
  localparam logic [DATA_W-1:0] ID_W    = DATA_W'(ID_VAL);

  typedef enum logic [1:0] {ST_HOLD, ST_WARM, ST_RUN} bus_state_e;

  bus_state_e state, stateNext;

  logic [DATA_W-1:0] scratch [NUM_REGS];
  logic [DATA_W-1:0] wrCount;
  logic              lock;
  logic [DATA_W-1:0] rdMux;
  logic              accept, writeAcc, readAcc, isScratch;

  // Stall is held for one extra cycle after reset release before going idle.
  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) state <= ST_HOLD;
    else                   state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_HOLD: stateNext = ST_WARM;
      ST_WARM: stateNext = ST_RUN;
      default: stateNext = ST_RUN;
    endcase
  end

  assign avs_Reg_waitrequest = (state != ST_RUN);
  assign accept    = !avs_Reg_waitrequest;
  assign writeAcc  = accept && avs_Reg_write;
  assign readAcc   = accept && avs_Reg_read && !avs_Reg_write;
  assign isScratch = (avs_Reg_address >= ADDR_W'(3));

  // Entries 0..2 of scratch never change after reset and reduce to constants.
  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) scratch[r] <= RESET_W;
      wrCount <= '0;
      lock    <= 1'b0;
    end else if (writeAcc) begin
      if (isScratch) begin
        if (!lock && (|avs_Reg_byteenable)) begin
          for (int unsigned i = 0; i < LANES; i++)
            if (avs_Reg_byteenable[i])
              scratch[avs_Reg_address][8*i +: 8] <= avs_Reg_writedata[8*i +: 8];
          wrCount <= wrCount + DATA_W'(1);
        end
      end else if (avs_Reg_address == ADDR_W'(2) && avs_Reg_byteenable[0]) begin
        lock <= avs_Reg_writedata[0];
      end
    end
  end

  always_comb begin
    rdMux = '0;
    case (avs_Reg_address)
      ADDR_W'(0): rdMux = ID_W;
      ADDR_W'(1): rdMux = wrCount;
      ADDR_W'(2): rdMux[0] = lock;
      default:    rdMux = scratch[avs_Reg_address];
    endcase
  end

  always_ff @(posedge csi_MCLK_clk) begin
    if (!rsi_MRST_reset_n) begin
      avs_Reg_readdata      <= '0;
      avs_Reg_readdatavalid <= 1'b0;
    end else begin
      avs_Reg_readdatavalid <= readAcc;
      if (readAcc) avs_Reg_readdata <= rdMux;
    end
  end

endmodule

// File: tb/tb_qsys_regfile_rw.sv
// Directed bench: 32-bit default instance for the register map, 16-bit
// instance for counter wrap and reset during a read.
module tb_qsys_regfile_rw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // 32-bit instance
  logic        rstA = 1'b0;
  logic [2:0]  addrA = '0;
  logic [3:0]  beA = '0;
  logic        rdA = 1'b0, wrA = 1'b0;
  logic [31:0] wdA = '0;
  logic [31:0] rdataA;
  logic        rvA, waitA;

  // 16-bit instance
  logic        rstB = 1'b0;
  logic [2:0]  addrB = '0;
  logic [1:0]  beB = '0;
  logic        rdB = 1'b0, wrB = 1'b0;
  logic [15:0] wdB = '0;
  logic [15:0] rdataB;
  logic        rvB, waitB;

  qsys_regfile_rw dutA (
    .csi_MCLK_clk(clk), .rsi_MRST_reset_n(rstA),
    .avs_Reg_address(addrA), .avs_Reg_byteenable(beA),
    .avs_Reg_read(rdA), .avs_Reg_readdata(rdataA),
    .avs_Reg_readdatavalid(rvA), .avs_Reg_write(wrA),
    .avs_Reg_writedata(wdA), .avs_Reg_waitrequest(waitA)
  );

  qsys_regfile_rw #(.DATA_W(16), .ADDR_W(3)) dutB (
    .csi_MCLK_clk(clk), .rsi_MRST_reset_n(rstB),
    .avs_Reg_address(addrB), .avs_Reg_byteenable(beB),
    .avs_Reg_read(rdB), .avs_Reg_readdata(rdataB),
    .avs_Reg_readdatavalid(rvB), .avs_Reg_write(wrB),
    .avs_Reg_writedata(wdB), .avs_Reg_waitrequest(waitB)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic writeA(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    @(negedge clk);
    wrA = 1'b1; addrA = a; wdA = d; beA = be;
    @(negedge clk);
    wrA = 1'b0; beA = '0;
  endtask

  task automatic readA(input logic [2:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    rdA = 1'b1; addrA = a;
    @(negedge clk);
    rdA = 1'b0;
    checkVal({tag, "_valid"}, {31'b0, rvA}, 32'd1);
    checkVal(tag, rdataA, exp);
    @(negedge clk);
    checkVal({tag, "_valid0"}, {31'b0, rvA}, 32'd0);
    checkVal({tag, "_hold"}, rdataA, exp);
  endtask

  task automatic writeB(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    @(negedge clk);
    wrB = 1'b1; addrB = a; wdB = d; beB = be;
    @(negedge clk);
    wrB = 1'b0; beB = '0;
  endtask

  task automatic readB(input logic [2:0] a, input logic [15:0] exp, input string tag);
    @(negedge clk);
    rdB = 1'b1; addrB = a;
    @(negedge clk);
    rdB = 1'b0;
    checkVal({tag, "_valid"}, {31'b0, rvB}, 32'd1);
    checkVal(tag, {16'b0, rdataB}, {16'b0, exp});
    @(negedge clk);
    checkVal({tag, "_valid0"}, {31'b0, rvB}, 32'd0);
  endtask

  task automatic waitReadyB();
    int n = 0;
    while (waitB && n < 8) begin
      @(negedge clk);
      n++;
    end
    checkVal("B_ready", {31'b0, waitB}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1);
  end

  initial begin
    // reset and stall release timing
    repeat (3) @(negedge clk);
    checkVal("rst_wait", {31'b0, waitA}, 32'd1);
    checkVal("rst_valid", {31'b0, rvA}, 32'd0);
    checkVal("rst_rdata", rdataA, 32'd0);
    rstA = 1'b1;
    @(negedge clk);
    checkVal("wait_first", {31'b0, waitA}, 32'd1);
    @(negedge clk);
    checkVal("wait_second", {31'b0, waitA}, 32'd0);

    readA(3'd0, 32'h52475731, "id");
    readA(3'd1, 32'h0, "cnt0");
    readA(3'd2, 32'h0, "ctrl0");
    readA(3'd3, 32'h12345678, "scr3_rst");

    // byteenable merge
    writeA(3'd3, 32'hDEADBEEF, 4'b0101);
    readA(3'd3, 32'h12AD56EF, "scr3_be");
    readA(3'd1, 32'd1, "cnt1");

    // lock blocks scratch writes and counting
    writeA(3'd2, 32'h1, 4'b0001);
    readA(3'd2, 32'h1, "ctrl_lock");
    writeA(3'd4, 32'hCAFEF00D, 4'b1111);
    readA(3'd4, 32'h12345678, "scr4_locked");
    readA(3'd1, 32'd1, "cnt_locked");
    writeA(3'd2, 32'h0, 4'b1110);
    readA(3'd2, 32'h1, "ctrl_be0_off");
    writeA(3'd2, 32'hFFFFFFFE, 4'b1111);
    readA(3'd2, 32'h0, "ctrl_unlock");
    writeA(3'd4, 32'hCAFEF00D, 4'b1111);
    readA(3'd4, 32'hCAFEF00D, "scr4_unlocked");
    readA(3'd1, 32'd2, "cnt2");
    writeA(3'd2, 32'hFFFFFFFF, 4'b1111);
    readA(3'd2, 32'h1, "ctrl_upper0");
    writeA(3'd2, 32'h0, 4'b0001);

    // ignored writes
    writeA(3'd0, 32'hFFFFFFFF, 4'b1111);
    writeA(3'd1, 32'hFFFFFFFF, 4'b1111);
    writeA(3'd5, 32'h00000000, 4'b0000);
    readA(3'd0, 32'h52475731, "id_ro");
    readA(3'd1, 32'd2, "cnt_ro");
    readA(3'd5, 32'h12345678, "scr5_be0");

    // back-to-back reads
    @(negedge clk);
    rdA = 1'b1; addrA = 3'd3;
    @(negedge clk);
    checkVal("b2b3_valid", {31'b0, rvA}, 32'd1);
    checkVal("b2b3", rdataA, 32'h12AD56EF);
    addrA = 3'd4;
    @(negedge clk);
    checkVal("b2b4_valid", {31'b0, rvA}, 32'd1);
    checkVal("b2b4", rdataA, 32'hCAFEF00D);
    addrA = 3'd5;
    @(negedge clk);
    rdA = 1'b0;
    checkVal("b2b5_valid", {31'b0, rvA}, 32'd1);
    checkVal("b2b5", rdataA, 32'h12345678);
    @(negedge clk);
    checkVal("b2b_end", {31'b0, rvA}, 32'd0);

    // read and write together: write wins, no response
    rdA = 1'b1; wrA = 1'b1; addrA = 3'd5; wdA = 32'h1; beA = 4'b1111;
    @(negedge clk);
    rdA = 1'b0; wrA = 1'b0; beA = '0;
    checkVal("rw_novalid", {31'b0, rvA}, 32'd0);
    @(negedge clk);
    checkVal("rw_novalid2", {31'b0, rvA}, 32'd0);
    readA(3'd5, 32'h1, "scr5_rw");
    readA(3'd1, 32'd3, "cnt3");

    // 16-bit counter wrap
    @(negedge clk);
    rstB = 1'b1;
    waitReadyB();
    @(negedge clk);
    wrB = 1'b1; addrB = 3'd3; wdB = 16'hA5A5; beB = 2'b11;
    for (int i = 0; i < 65535; i++) @(negedge clk);
    wrB = 1'b0; beB = '0;
    readB(3'd1, 16'hFFFF, "B_cnt_max");
    readB(3'd3, 16'hA5A5, "B_scr3");
    writeB(3'd3, 16'h1234, 2'b01);
    readB(3'd1, 16'h0000, "B_cnt_wrap");
    readB(3'd3, 16'hA534, "B_scr3_be");
    writeB(3'd2, 16'h0001, 2'b01);
    readB(3'd2, 16'h0001, "B_lock");

    // reset coincident with a read request
    @(negedge clk);
    rdB = 1'b1; addrB = 3'd3; rstB = 1'b0;
    @(negedge clk);
    rdB = 1'b0;
    checkVal("B_rst_valid", {31'b0, rvB}, 32'd0);
    checkVal("B_rst_wait", {31'b0, waitB}, 32'd1);
    checkVal("B_rst_rdata", {16'b0, rdataB}, 32'd0);
    @(negedge clk);
    rstB = 1'b1;
    waitReadyB();
    readB(3'd0, 16'h5731, "B_id");
    readB(3'd1, 16'h0000, "B_cnt_rst");
    readB(3'd2, 16'h0000, "B_ctrl_rst");
    readB(3'd3, 16'h5678, "B_scr3_rst");
    readB(3'd7, 16'h5678, "B_scr7_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
